key_reader: RTL and testbench

KEY_READER -- requirements
Module: key_reader

---
 rtl/key_reader.sv | 183 ++++++++++++++++++
 tb/tb_key_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_reader: keypad handshake and two-operand entry for a calculator.      |
// | Optional macro KEYRD_HOLD_EN turns KeyRd into a level acknowledge.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module key_reader #(
    parameter int MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        KeyRdy,
    output logic        KeyRd,
    input  logic [3:0]  keypad_input,
    input  logic [2:0]  operator_input,
    input  logic        equal_input,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [2:0]  opcode,
    output logic        calc_valid,
    input  logic        calc_ready,
    output logic [15:0] display,
    output logic        entry_ovf
);
    localparam int                 c_CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_state_t;

    typedef enum logic [1:0] {
        EN_A     = 2'd0,
        EN_B     = 2'd1,
        EN_ISSUE = 2'd2
    } en_state_t;

    hs_state_t          r_hs;
    en_state_t          r_en;
    logic               r_a_neg, r_b_neg;
    logic [14:0]        r_a_mag, r_b_mag;
    logic [c_CNT_W-1:0] r_a_cnt, r_b_cnt;
    logic [15:0]        r_op_a, r_op_b;
    logic [2:0]         r_opcode;
    logic               r_calc_valid;
    logic               r_keyrd;
    logic               r_ovf;

    logic               w_key_accept;
    logic               w_is_equal;
    logic               w_is_op;
    logic               w_is_arith;
    logic [14:0]        w_cur_mag;
    logic [c_CNT_W-1:0] w_cur_cnt;
    logic [19:0]        w_next_mag;
    logic               w_digit_ok;

    // Two's-complement of sign/magnitude; a negative zero naturally yields 0.
    function automatic logic [15:0] f_signed(input logic neg, input logic [14:0] mag);
        return neg ? (16'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

    assign w_key_accept = (r_hs == HS_IDLE) && KeyRdy && (r_en != EN_ISSUE);
    assign w_is_equal   = equal_input;
    assign w_is_op      = !equal_input && (operator_input != 3'b000);
    assign w_is_arith   = (operator_input == 3'b010) || (operator_input == 3'b011) ||
                          (operator_input == 3'b100);
    assign w_cur_mag    = (r_en == EN_A) ? r_a_mag : r_b_mag;
    assign w_cur_cnt    = (r_en == EN_A) ? r_a_cnt : r_b_cnt;
    assign w_next_mag   = ({5'd0, w_cur_mag} * 20'd10) + {16'd0, keypad_input};
    assign w_digit_ok   = (w_cur_cnt < c_MAX_CNT) && (w_next_mag <= 20'd32767);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_hs         <= HS_IDLE;
            r_en         <= EN_A;
            r_a_neg      <= 1'b0;
            r_a_mag      <= 15'd0;
            r_a_cnt      <= '0;
            r_b_neg      <= 1'b0;
            r_b_mag      <= 15'd0;
            r_b_cnt      <= '0;
            r_op_a       <= 16'd0;
            r_op_b       <= 16'd0;
            r_opcode     <= 3'b000;
            r_calc_valid <= 1'b0;
            r_keyrd      <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_ovf <= 1'b0;

            case (r_hs)
                HS_IDLE: begin
                    if (w_key_accept) begin
                        r_hs    <= HS_ACK;
                        r_keyrd <= 1'b1;
                    end
                end
                HS_ACK: begin
                    r_hs <= HS_WAIT_LOW;
`ifdef KEYRD_HOLD_EN
                    r_keyrd <= 1'b1;
`else
                    r_keyrd <= 1'b0;
`endif
                end
                HS_WAIT_LOW: begin
                    if (!KeyRdy) begin
                        r_hs    <= HS_IDLE;
                        r_keyrd <= 1'b0;
                    end
                end
                default: begin
                    r_hs    <= HS_IDLE;
                    r_keyrd <= 1'b0;
                end
            endcase

            // Keys cannot arrive in ISSUE, so the two branches never overlap.
            if (r_en == EN_ISSUE) begin
                if (calc_ready) begin
                    r_en         <= EN_A;
                    r_calc_valid <= 1'b0;
                    r_a_neg      <= 1'b0;
                    r_a_mag      <= 15'd0;
                    r_a_cnt      <= '0;
                    r_b_neg      <= 1'b0;
                    r_b_mag      <= 15'd0;
                    r_b_cnt      <= '0;
                    r_op_a       <= 16'd0;
                    r_op_b       <= 16'd0;
                    r_opcode     <= 3'b000;
                end
            end else if (w_key_accept) begin
                if (w_is_equal) begin
                    if (r_en == EN_B) begin
                        r_op_b       <= f_signed(r_b_neg, r_b_mag);
                        r_calc_valid <= 1'b1;
                        r_en         <= EN_ISSUE;
                    end
                end else if (w_is_op) begin
                    if (operator_input == 3'b001) begin
                        if (r_en == EN_A) r_a_neg <= !r_a_neg;
                        else              r_b_neg <= !r_b_neg;
                    end else if (w_is_arith) begin
                        if (r_en == EN_A) begin
                            r_op_a   <= f_signed(r_a_neg, r_a_mag);
                            r_opcode <= operator_input;
                            r_b_neg  <= 1'b0;
                            r_b_mag  <= 15'd0;
                            r_b_cnt  <= '0;
                            r_en     <= EN_B;
                        end else if (r_b_cnt == '0) begin
                            r_opcode <= operator_input;
                        end
                    end
                end else if (w_digit_ok) begin
                    if (r_en == EN_A) begin
                        r_a_mag <= w_next_mag[14:0];
                        r_a_cnt <= r_a_cnt + c_CNT_W'(1);
                    end else begin
                        r_b_mag <= w_next_mag[14:0];
                        r_b_cnt <= r_b_cnt + c_CNT_W'(1);
                    end
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign KeyRd      = r_keyrd;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign opcode     = r_opcode;
    assign calc_valid = r_calc_valid;
    assign entry_ovf  = r_ovf;
    assign display    = (r_en == EN_A) ? f_signed(r_a_neg, r_a_mag) : f_signed(r_b_neg, r_b_mag);

endmodule
`default_nettype wire

// File: tb/tb_key_reader.sv
`default_nettype none
// Testbench for key_reader: directed scenarios plus random key streams
// checked against an arithmetic model of operand entry.
`timescale 1ns/1ps
module tb_key_reader;
    localparam int MAX_DIGITS = 5;

    logic        clk = 1'b0;
    logic        RST;
    logic        KeyRdy;
    logic        KeyRd;
    logic [3:0]  keypad_input;
    logic [2:0]  operator_input;
    logic        equal_input;
    logic [15:0] op_a, op_b, display;
    logic [2:0]  opcode;
    logic        calc_valid;
    logic        calc_ready;
    logic        entry_ovf;

    int errors = 0;
    int checks = 0;
    int ovf_count = 0;

    // Model: index 0 is operand A, 1 is operand B; mode 0=A, 1=B, 2=issue.
    int          m_mag[2];
    bit          m_neg[2];
    int          m_cnt[2];
    int          m_mode;
    logic [2:0]  m_opcode;
    logic [15:0] m_op_a, m_op_b;
    bit          m_ovf;

    always #5 clk = ~clk;

    always @(negedge clk) if (entry_ovf === 1'b1) ovf_count++;

    key_reader #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk(clk), .RST(RST), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
        .keypad_input(keypad_input), .operator_input(operator_input),
        .equal_input(equal_input), .op_a(op_a), .op_b(op_b), .opcode(opcode),
        .calc_valid(calc_valid), .calc_ready(calc_ready), .display(display),
        .entry_ovf(entry_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sval(input bit neg, input int mag);
        int v;
        v = neg ? -mag : mag;
        return v[15:0];
    endfunction

    function automatic logic [15:0] m_disp();
        return (m_mode == 0) ? sval(m_neg[0], m_mag[0]) : sval(m_neg[1], m_mag[1]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_mag[i] = 0; m_neg[i] = 0; m_cnt[i] = 0;
        end
        m_mode = 0;
        m_ovf  = 0;
    endtask

    // kind: 0 digit, 1 operator, 2 equal
    task automatic model_key(input int kind, input int val);
        int cur;
        cur   = (m_mode == 0) ? 0 : 1;
        m_ovf = 0;
        if (kind == 2) begin
            if (m_mode == 1) begin
                m_op_b = sval(m_neg[1], m_mag[1]);
                m_mode = 2;
            end
        end else if (kind == 1) begin
            if (val == 1) m_neg[cur] = !m_neg[cur];
            else if (m_mode == 0) begin
                m_op_a   = sval(m_neg[0], m_mag[0]);
                m_opcode = val[2:0];
                m_mag[1] = 0; m_neg[1] = 0; m_cnt[1] = 0;
                m_mode   = 1;
            end else if (m_cnt[1] == 0) m_opcode = val[2:0];
        end else begin
            if (m_cnt[cur] < MAX_DIGITS && m_mag[cur] * 10 + val <= 32767) begin
                m_mag[cur] = m_mag[cur] * 10 + val;
                m_cnt[cur]++;
            end else m_ovf = 1;
        end
    endtask

    task automatic set_key(input int kind, input int val);
        keypad_input   = 4'($urandom_range(0, 9));
        operator_input = 3'b000;
        equal_input    = 1'b0;
        if (kind == 0) keypad_input = 4'(val);
        else if (kind == 1) operator_input = 3'(val);
        else begin
            equal_input    = 1'b1;
            operator_input = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic key_start(input int kind, input int val, input string tag);
        int got;
        @(negedge clk);
        set_key(kind, val);
        KeyRdy = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(posedge clk); #1;
            if (KeyRd === 1'b1) got = 1;
        end
        check({tag, " ack"}, got, 1);
        model_key(kind, val);
        check({tag, " display"}, display, m_disp());
        check({tag, " ovf"}, entry_ovf, m_ovf);
        check({tag, " valid"}, calc_valid, (m_mode == 2));
    endtask

    task automatic key_finish();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(negedge clk);
        KeyRdy = 1'b0;
        @(posedge clk); #1;
        check("ovf single pulse", entry_ovf, 0);
        @(posedge clk); #1;
        check("keyrd released", KeyRd, 0);
    endtask

    task automatic press(input int kind, input int val, input string tag);
        key_start(kind, val, tag);
        key_finish();
    endtask

    task automatic check_issue(input string tag);
        check({tag, " op_a"}, op_a, m_op_a);
        check({tag, " op_b"}, op_b, m_op_b);
        check({tag, " opcode"}, opcode, m_opcode);
    endtask

    task automatic issue_release(input string tag);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            check({tag, " valid held"}, calc_valid, 1);
            check_issue({tag, " held"});
        end
        @(negedge clk);
        calc_ready = 1'b1;
        @(posedge clk); #1;
        model_clear();
        check({tag, " valid cleared"}, calc_valid, 0);
        check({tag, " display cleared"}, display, m_disp());
        @(negedge clk);
        calc_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1; KeyRdy = 1'b0; calc_ready = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int highs, rises, base, r, v;
        logic prev;
        RST = 1'b1; KeyRdy = 1'b0; calc_ready = 1'b0;
        keypad_input = 4'd0; operator_input = 3'b000; equal_input = 1'b0;
        model_clear();
        #12;
        check("reset KeyRd", KeyRd, 0);
        check("reset calc_valid", calc_valid, 0);
        check("reset entry_ovf", entry_ovf, 0);
        check("reset op_a", op_a, 0);
        check("reset op_b", op_b, 0);
        check("reset opcode", opcode, 0);
        check("reset display", display, 0);
        @(negedge clk);
        RST = 1'b0;

        // 123 + 45 with calc_ready held high: single calc_valid cycle
        calc_ready = 1'b1;
        press(0, 1, "s30 d1"); press(0, 2, "s30 d2"); press(0, 3, "s30 d3");
        press(1, 2, "s30 add"); press(0, 4, "s30 d4"); press(0, 5, "s30 d5");
        key_start(2, 0, "s30 eq");
        check("s30 op_a", op_a, 16'd123);
        check("s30 op_b", op_b, 16'd45);
        check("s30 opcode", opcode, 3'b010);
        @(posedge clk); #1;
        model_clear();
        check("s30 one valid cycle", calc_valid, 0);
        check("s30 display zero", display, 0);
        key_finish();
        calc_ready = 1'b0;

        // 32767 fills MAX_DIGITS; sixth digit dropped
        do_reset();
        base = ovf_count;
        press(0, 3, "s31 d"); press(0, 2, "s31 d"); press(0, 7, "s31 d");
        press(0, 6, "s31 d"); press(0, 7, "s31 d");
        key_start(0, 9, "s31 d9");
        check("s31 display max", display, 16'h7FFF);
        key_finish();
        check("s31 ovf pulses", ovf_count - base, 1);

        // fewer than MAX_DIGITS but value would exceed 32767
        do_reset();
        press(0, 4, "big d"); press(0, 0, "big d"); press(0, 0, "big d"); press(0, 0, "big d");
        key_start(0, 0, "big d0");
        check("big display", display, 16'd4000);
        check("big ovf", entry_ovf, 1);
        key_finish();

        // 5 neg mul 6 neg =
        do_reset();
        press(0, 5, "s32 d5"); press(1, 1, "s32 neg"); press(1, 4, "s32 mul");
        press(0, 6, "s32 d6"); press(1, 1, "s32 neg");
        key_start(2, 0, "s32 eq");
        check("s32 op_a", op_a, 16'hFFFB);
        check("s32 op_b", op_b, 16'hFFFA);
        check("s32 opcode", opcode, 3'b100);
        issue_release("s32");
        key_finish();

        // equal ignored in A, neg zero, operator replace then ignore in B
        do_reset();
        press(2, 0, "rep eqA"); press(1, 1, "rep negzero");
        check("rep negzero display", display, 0);
        press(0, 8, "rep d8");
        check("rep neg8", display, 16'hFFF8);
        press(1, 2, "rep add"); press(1, 3, "rep sub"); press(1, 1, "rep negB");
        press(0, 2, "rep d2"); press(1, 4, "rep mul ignored");
        key_start(2, 0, "rep eq");
        check("rep op_a", op_a, 16'hFFF8);
        check("rep op_b", op_b, 16'hFFFE);
        check("rep opcode", opcode, 3'b011);
        check_issue("rep");
        issue_release("rep");
        key_finish();

        // key pending while calculator stalls
        do_reset();
        press(0, 1, "s34 d1"); press(1, 2, "s34 add"); press(0, 2, "s34 d2");
        key_start(2, 0, "s34 eq");
        key_finish();
        @(negedge clk);
        set_key(0, 7);
        KeyRdy = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("s34 no ack in issue", KeyRd, 0);
            check("s34 valid held", calc_valid, 1);
        end
        @(negedge clk);
        calc_ready = 1'b1;
        @(posedge clk); #1;
        model_clear();
        check("s34 no ack on release edge", KeyRd, 0);
        check("s34 valid drop", calc_valid, 0);
        check("s34 display cleared", display, 0);
        @(negedge clk);
        calc_ready = 1'b0;
        @(posedge clk); #1;
        model_key(0, 7);
        check("s34 ack next cycle", KeyRd, 1);
        check("s34 display", display, m_disp());
        key_finish();

        // KeyRdy held for 20 cycles
        do_reset();
        @(negedge clk);
        set_key(0, 9);
        KeyRdy = 1'b1;
        highs = 0; rises = 0; prev = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (KeyRd === 1'b1) highs++;
            if (KeyRd === 1'b1 && prev !== 1'b1) rises++;
            prev = KeyRd;
        end
        model_key(0, 9);
        check("s33 rises", rises, 1);
`ifdef KEYRD_HOLD_EN
        check("s33 level cycles", highs, 20);
`else
        check("s33 pulse cycles", highs, 1);
`endif
        check("s33 one digit", display, 16'd9);
        @(negedge clk);
        KeyRdy = 1'b0;
        @(posedge clk); #1;
        check("s33 keyrd low", KeyRd, 0);

        // asynchronous reset while in ACK; held KeyRdy is a new key
        do_reset();
        press(0, 4, "s35 d4");
        @(negedge clk);
        set_key(0, 6);
        KeyRdy = 1'b1;
        @(posedge clk); #1;
        check("s35 in ack", KeyRd, 1);
        check("s35 display46", display, 16'd46);
        RST = 1'b1;
        #1;
        model_clear();
        check("s35 KeyRd", KeyRd, 0);
        check("s35 display", display, 0);
        check("s35 op_a", op_a, 0);
        check("s35 op_b", op_b, 0);
        check("s35 opcode", opcode, 0);
        check("s35 calc_valid", calc_valid, 0);
        check("s35 entry_ovf", entry_ovf, 0);
        @(negedge clk);
        RST = 1'b0;
        @(posedge clk); #1;
        model_key(0, 6);
        check("s35 new key ack", KeyRd, 1);
        check("s35 new key display", display, m_disp());
        key_finish();

        // random key streams
        do_reset();
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      begin v = $urandom_range(0, 9); key_start(0, v, "rnd digit"); end
            else if (r < 85) begin v = $urandom_range(1, 4); key_start(1, v, "rnd op"); end
            else             begin v = 0;                    key_start(2, v, "rnd eq"); end
            if (m_mode == 2) begin
                check_issue("rnd issue");
                issue_release("rnd");
            end
            key_finish();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
